ring_osc_freq_meter: RTL and testbench

Downstream consumer of the tapped ring-oscillator output. It measures oscillator frequency in the system clock domain. The block synchronises the asynchronous oscillator (or a prescaled copy of it) into clk, detects rising edges, and counts them over a gate window of 2^gate_sel clk cycles. It then publishes the result with a one-cycle valid strobe, so tap settings can be characterised without an external frequency counter.

---
 rtl/ring_osc_freq_meter_if.sv | 24 ++
 rtl/ring_osc_freq_meter.sv | 136 +++++++++++++
 tb/tb_ring_osc_freq_meter.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ring_osc_freq_meter_if.sv
// Signal bundle between a frequency-meter client and the ring-oscillator meter.
// The master drives the oscillator and control inputs and receives the measurement.
interface ring_osc_freq_meter_if #(
  parameter int CNT_W = 16
);
  logic             osc_in;
  logic             start;
  logic             cont;
  logic [3:0]       gate_sel;
  logic [CNT_W-1:0] result;
  logic             valid;
  logic             busy;
  logic             overflow;

  modport master (
    output osc_in, start, cont, gate_sel,
    input  result, valid, busy, overflow
  );

  modport slave (
    input  osc_in, start, cont, gate_sel,
    output result, valid, busy, overflow
  );
endinterface

// File: rtl/ring_osc_freq_meter.sv
// Counts synchronised rising edges of an asynchronous oscillator over a window of
// 2^gate_sel clk cycles and publishes the saturating count with a one-cycle strobe.
module ring_osc_freq_meter #(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  ring_osc_freq_meter_if.slave  bus
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_MEASURE = 2'd1;
  localparam logic [1:0] S_DONE    = 2'd2;

  logic [1:0]             state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic [CNT_W-1:0]       edge_cnt_q, edge_cnt_d;
  logic                   ovf_int_q, ovf_int_d;
  logic [15:0]            gate_cnt_q, gate_cnt_d;
  logic                   after_done_q, after_done_d;
  logic                   busy_q, busy_d;
  logic                   valid_q;
  logic                   overflow_q;
  logic [CNT_W-1:0]       result_q;
  logic                   rise_s;
  logic                   win_end_s;

  assign rise_s = sync_q[SYNC_STAGES-1] & ~prev_q;

  assign bus.result   = result_q;
  assign bus.valid    = valid_q;
  assign bus.busy     = busy_q;
  assign bus.overflow = overflow_q;

  // Next-state and counter update logic for the IDLE/MEASURE/DONE sequencer
  always_comb begin
    state_d      = state_q;
    edge_cnt_d   = edge_cnt_q;
    ovf_int_d    = ovf_int_q;
    gate_cnt_d   = gate_cnt_q;
    after_done_d = 1'b0;
    busy_d       = busy_q;
    win_end_s    = 1'b0;
    case (state_q)
      S_IDLE: begin
        // cont only restarts a chain that has already produced a DONE
        if (bus.start || (bus.cont && after_done_q)) begin
          state_d    = S_MEASURE;
          gate_cnt_d = (16'd1 << bus.gate_sel) - 16'd1;
          edge_cnt_d = '0;
          ovf_int_d  = 1'b0;
          busy_d     = 1'b1;
        end else begin
          state_d    = S_IDLE;
        end
      end
      S_MEASURE: begin
        if (rise_s) begin
          if (edge_cnt_q == {CNT_W{1'b1}}) begin
            ovf_int_d  = 1'b1;
          end else begin
            edge_cnt_d = edge_cnt_q + CNT_W'(1);
          end
        end else begin
          edge_cnt_d = edge_cnt_q;
        end
        if (gate_cnt_q == 16'd0) begin
          state_d    = S_DONE;
          win_end_s  = 1'b1;
        end else begin
          gate_cnt_d = gate_cnt_q - 16'd1;
        end
      end
      S_DONE: begin
        state_d      = S_IDLE;
        after_done_d = 1'b1;
        busy_d       = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Synchroniser chain and edge-detect history
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], bus.osc_in};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  // Sequencer state and counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      edge_cnt_q   <= '0;
      ovf_int_q    <= 1'b0;
      gate_cnt_q   <= 16'd0;
      after_done_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      edge_cnt_q   <= edge_cnt_d;
      ovf_int_q    <= ovf_int_d;
      gate_cnt_q   <= gate_cnt_d;
      after_done_q <= after_done_d;
      busy_q       <= busy_d;
    end
  end

  // Result registers load on the last window cycle so they are visible with valid in DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q   <= '0;
      overflow_q <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      valid_q <= win_end_s;
      if (win_end_s) begin
        result_q   <= edge_cnt_d;
        overflow_q <= ovf_int_d;
      end else begin
        result_q   <= result_q;
        overflow_q <= overflow_q;
      end
    end
  end

endmodule

// File: tb/tb_ring_osc_freq_meter.sv
// Bench for ring_osc_freq_meter: a 16-bit and a 4-bit instance see identical stimulus,
// expected results are queued when start is driven and compared when valid appears.
module tb_ring_osc_freq_meter;

  typedef struct {
    int cyc;
    int lo;
    int hi;
    bit ovf;
  } exp_t;

  typedef struct {
    int gsel;
    int half;
    bit lvl;
    int lo;
    int hi;
    bit ovf;
    int slo;
    int shi;
    bit sovf;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       osc = 1'b0;
  logic       start;
  logic       cont;
  logic [3:0] gsel;

  int   cyc = 0;
  int   osc_half = 0;
  bit   osc_level = 1'b0;
  int   ocnt = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t q_w[$];
  exp_t q_n[$];
  vec_t vecs[8];

  ring_osc_freq_meter_if #(.CNT_W(16)) bus_w ();
  ring_osc_freq_meter_if #(.CNT_W(4))  bus_n ();

  assign bus_w.osc_in   = osc;
  assign bus_w.start    = start;
  assign bus_w.cont     = cont;
  assign bus_w.gate_sel = gsel;
  assign bus_n.osc_in   = osc;
  assign bus_n.start    = start;
  assign bus_n.cont     = cont;
  assign bus_n.gate_sel = gsel;

  ring_osc_freq_meter #(.CNT_W(16), .SYNC_STAGES(2)) dut_w (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_w)
  );

  ring_osc_freq_meter #(.CNT_W(4), .SYNC_STAGES(2)) dut_n (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_n)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  // Oscillator model: held at osc_level when osc_half is 0, else toggles every osc_half clks
  always @(negedge clk) begin
    if (osc_half == 0) begin
      osc  = osc_level;
      ocnt = 0;
    end else begin
      ocnt = ocnt + 1;
      if (ocnt >= osc_half) begin
        ocnt = 0;
        osc  = ~osc;
      end
    end
  end

  task automatic chk(input string name, input bit ok, input int act, input int lo, input int hi);
    checks = checks + 1;
    if (!ok) begin
      errors = errors + 1;
      $display("FAIL %s: actual %0d required %0d..%0d (cycle %0d)", name, act, lo, hi, cyc);
    end
  endtask

  task automatic mon(input int which, input bit v, input int res, input bit ov, input bit bsy);
    exp_t  e;
    string tag;
    tag = (which == 0) ? "w" : "n";
    if (v) begin
      if ((which == 0 && q_w.size() == 0) || (which == 1 && q_n.size() == 0)) begin
        chk({tag, "_unexpected_valid"}, 1'b0, cyc, -1, -1);
      end else begin
        e = (which == 0) ? q_w.pop_front() : q_n.pop_front();
        chk({tag, "_valid_cycle"}, cyc == e.cyc, cyc, e.cyc, e.cyc);
        chk({tag, "_result"}, res >= e.lo && res <= e.hi, res, e.lo, e.hi);
        chk({tag, "_overflow"}, ov == e.ovf, int'(ov), int'(e.ovf), int'(e.ovf));
        chk({tag, "_busy_at_valid"}, bsy, int'(bsy), 1, 1);
      end
    end
  endtask

  task automatic do_start(input int g, output int vcyc);
    @(negedge clk);
    gsel  = 4'(g);
    start = 1'b1;
    vcyc  = cyc + 1 + (1 << g);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic push(input int vcyc, input vec_t v);
    q_w.push_back('{cyc: vcyc, lo: v.lo, hi: v.hi, ovf: v.ovf});
    q_n.push_back('{cyc: vcyc, lo: v.slo, hi: v.shi, ovf: v.sovf});
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while ((q_w.size() != 0 || q_n.size() != 0) && n < budget) begin
      @(negedge clk);
      n = n + 1;
    end
    chk("drain_timeout", q_w.size() == 0 && q_n.size() == 0, q_w.size() + q_n.size(), 0, 0);
    q_w.delete();
    q_n.delete();
  endtask

  task automatic wait_valid(input int budget, input string name);
    int n;
    n = 0;
    while (bus_w.valid !== 1'b1 && n < budget) begin
      @(negedge clk);
      n = n + 1;
    end
    chk(name, bus_w.valid === 1'b1, n, 0, budget - 1);
  endtask

  initial begin
    int   vc;
    vec_t v8;
    vecs[0] = '{gsel: 6,  half: 4, lvl: 1'b0, lo: 7,    hi: 9,    ovf: 1'b0, slo: 7,  shi: 9,  sovf: 1'b0};
    vecs[1] = '{gsel: 4,  half: 0, lvl: 1'b0, lo: 0,    hi: 0,    ovf: 1'b0, slo: 0,  shi: 0,  sovf: 1'b0};
    vecs[2] = '{gsel: 4,  half: 0, lvl: 1'b1, lo: 0,    hi: 0,    ovf: 1'b0, slo: 0,  shi: 0,  sovf: 1'b0};
    vecs[3] = '{gsel: 6,  half: 1, lvl: 1'b0, lo: 32,   hi: 32,   ovf: 1'b0, slo: 15, shi: 15, sovf: 1'b1};
    vecs[4] = '{gsel: 3,  half: 1, lvl: 1'b0, lo: 4,    hi: 4,    ovf: 1'b0, slo: 4,  shi: 4,  sovf: 1'b0};
    vecs[5] = '{gsel: 0,  half: 0, lvl: 1'b0, lo: 0,    hi: 0,    ovf: 1'b0, slo: 0,  shi: 0,  sovf: 1'b0};
    vecs[6] = '{gsel: 0,  half: 1, lvl: 1'b0, lo: 0,    hi: 1,    ovf: 1'b0, slo: 0,  shi: 1,  sovf: 1'b0};
    vecs[7] = '{gsel: 15, half: 2, lvl: 1'b0, lo: 8191, hi: 8193, ovf: 1'b0, slo: 15, shi: 15, sovf: 1'b1};
    v8      = '{gsel: 5,  half: 2, lvl: 1'b0, lo: 7,    hi: 9,    ovf: 1'b0, slo: 7,  shi: 9,  sovf: 1'b0};

    rst_n = 1'b0;
    start = 1'b0;
    cont  = 1'b0;
    gsel  = 4'd0;
    repeat (3) @(negedge clk);
    chk("reset_result",   bus_w.result == 16'd0, int'(bus_w.result), 0, 0);
    chk("reset_valid",    bus_w.valid == 1'b0, int'(bus_w.valid), 0, 0);
    chk("reset_busy",     bus_w.busy == 1'b0, int'(bus_w.busy), 0, 0);
    chk("reset_overflow", bus_w.overflow == 1'b0, int'(bus_w.overflow), 0, 0);
    rst_n = 1'b1;

    fork
      forever begin
        @(negedge clk);
        mon(0, bus_w.valid, int'(bus_w.result), bus_w.overflow, bus_w.busy);
        mon(1, bus_n.valid, int'(bus_n.result), bus_n.overflow, bus_n.busy);
      end
    join_none

    // Single-shot windows across patterns and gate lengths
    for (int i = 0; i < 8; i++) begin
      osc_half  = vecs[i].half;
      osc_level = vecs[i].lvl;
      repeat (8) @(negedge clk);
      do_start(vecs[i].gsel, vc);
      push(vc, vecs[i]);
      if (i == 0) begin
        chk("busy_after_accept", bus_w.busy == 1'b1, int'(bus_w.busy), 1, 1);
      end
      wait_drain((1 << vecs[i].gsel) + 20);
      if (i == 0) begin
        chk("busy_after_done", bus_w.busy == 1'b0, int'(bus_w.busy), 0, 0);
      end
      repeat (3) @(negedge clk);
    end

    // Continuous mode: three windows 34 cycles apart, one idle cycle between them
    osc_half = 2;
    cont     = 1'b1;
    repeat (8) @(negedge clk);
    do_start(5, vc);
    for (int k = 0; k < 3; k++) push(vc + 34 * k, v8);
    wait_valid(60, "cont_first_valid");
    @(negedge clk);
    chk("cont_busy_gap_low", bus_w.busy == 1'b0, int'(bus_w.busy), 0, 0);
    @(negedge clk);
    chk("cont_busy_restart", bus_w.busy == 1'b1, int'(bus_w.busy), 1, 1);
    @(negedge clk);
    wait_valid(60, "cont_second_valid");
    repeat (4) @(negedge clk);
    cont = 1'b0;
    wait_drain(60);
    repeat (60) @(negedge clk);
    chk("cont_stopped_busy", bus_w.busy == 1'b0, int'(bus_w.busy), 0, 0);

    // Second start during a long window must be ignored
    v8.lo = 63; v8.hi = 65; v8.slo = 15; v8.shi = 15; v8.sovf = 1'b1;
    do_start(8, vc);
    push(vc, v8);
    repeat (9) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_drain(300);
    repeat (30) @(negedge clk);

    // Asynchronous reset mid-measurement after a result of 8
    osc_half = 4;
    repeat (8) @(negedge clk);
    do_start(6, vc);
    push(vc, vecs[0]);
    wait_drain(90);
    @(negedge clk);
    chk("pre_reset_result", bus_w.result >= 16'd7 && bus_w.result <= 16'd9, int'(bus_w.result), 7, 9);
    do_start(6, vc);
    repeat (20) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_result",   bus_w.result == 16'd0, int'(bus_w.result), 0, 0);
    chk("async_rst_valid",    bus_w.valid == 1'b0, int'(bus_w.valid), 0, 0);
    chk("async_rst_busy",     bus_w.busy == 1'b0, int'(bus_w.busy), 0, 0);
    chk("async_rst_overflow", bus_n.overflow == 1'b0, int'(bus_n.overflow), 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (80) @(negedge clk);
    do_start(6, vc);
    push(vc, vecs[0]);
    wait_drain(90);
    repeat (5) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
